// File: rtl/axil_pkg.sv
// AXI4-Lite response codes and the master engine FSM state type.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } axil_mst_state_e;

endpackage

// File: rtl/m_axil_master_engine.sv
// AXI4-Lite master: one single-word command in flight, turned into an AW/W/B or AR/R
// transaction; sticky TIMEOUT flag for slaves that stall the bus.
module m_axil_master_engine
  import axil_pkg::*;
#(
  parameter int M_AXI_DATA_WIDTH = 32,  // 32 or 64
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic                          RSP_WRITE,
  output logic [M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          TIMEOUT,
  output logic [M_AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RVALID,
  output logic                          RREADY
);

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

  axil_mst_state_e state, state_d;

  logic                          live;
  logic [M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                          aw_done, w_done;
  logic [15:0]                   cnt;
  logic                          busy;

  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign busy    = (state == ST_WR_ADDR_DATA) || (state == ST_WR_RESP) ||
                   (state == ST_RD_ADDR)      || (state == ST_RD_DATA);

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d   = state;
    CMD_READY = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    RSP_VALID = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // live keeps CMD_READY low while reset is held, even though state is IDLE
        CMD_READY = live;
        if (live && CMD_VALID) state_d = CMD_WRITE ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      end
      ST_WR_ADDR_DATA: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_d = ST_RSP;
      end
      ST_RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        RREADY = 1'b1;
        if (RVALID) state_d = ST_RSP;
      end
      ST_RSP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      live      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= '0;
      cnt       <= '0;
      TIMEOUT   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (CMD_READY && CMD_VALID) begin
        addr_q  <= CMD_ADDR;
        wdata_q <= CMD_WDATA;
        wstrb_q <= CMD_WSTRB;
      end
      if (state == ST_WR_ADDR_DATA) begin
        if (AWVALID && AWREADY) aw_done <= 1'b1;
        if (WVALID && WREADY)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (BREADY && BVALID) begin
        RSP_WRITE <= 1'b1;
        RSP_RDATA <= '0;
        RSP_RESP  <= BRESP;
      end
      if (RREADY && RVALID) begin
        RSP_WRITE <= 1'b0;
        RSP_RDATA <= RDATA;
        RSP_RESP  <= RRESP;
      end
      // The stall is only flagged: AXI never allows a raised VALID to be withdrawn.
      if (state != ST_IDLE && state_d == ST_IDLE) cnt <= '0;
      else if (busy && cnt != '1)                 cnt <= cnt + 16'd1;
      if (TO_EN && busy && ({1'b0, cnt} + 17'd1) == TO_LIM) TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_axil_master_engine.sv
// Bench for m_axil_master_engine: register slave with steerable READY stalls, plus a
// word-array reference of what each command must return.
module tb_m_axil_master_engine;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_WDATA = '0;
  logic [SW-1:0] CMD_WSTRB = '0;
  logic          RSP_VALID, RSP_READY = 1'b0, RSP_WRITE, TIMEOUT;
  logic [DW-1:0] RSP_RDATA;
  logic [1:0]    RSP_RESP;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  m_axil_master_engine #(
    .M_AXI_DATA_WIDTH(DW),
    .M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .TIMEOUT(TIMEOUT),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Slave environment: READYs are low until cycle *_blk, then high (or random 3/4 of the time).
  int unsigned cyc = 0;
  logic [31:0] rnd = '0;
  bit          rand_rdy = 1'b0;
  int unsigned aw_blk = 0, w_blk = 0, ar_blk = 0;

  always @(posedge ACLK) cyc <= cyc + 1;
  always @(negedge ACLK) rnd <= $urandom;

  assign AWREADY = (cyc >= aw_blk) && (!rand_rdy || rnd[1:0] != 2'b00);
  assign WREADY  = (cyc >= w_blk)  && (!rand_rdy || rnd[3:2] != 2'b00);
  assign ARREADY = (cyc >= ar_blk) && (!rand_rdy || rnd[5:4] != 2'b00);

  // Slave address map: 0x00-0x3C plain registers, 0x40 SLVERR, 0x100 and up DECERR.
  function automatic logic [1:0] slv_resp(input logic [AW-1:0] a);
    if (a >= 32'h100) return 2'b11;
    if (a == 32'h40)  return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [31:0]   slv_mem [64] = '{default: '0};
  logic          aw_got = 1'b0, w_got = 1'b0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0, wa;
  logic [DW-1:0] s_wdata = '0, wd;
  logic [SW-1:0] s_wstrb = '0, ws;
  int            aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int unsigned   aw_cyc = 0, w_cyc = 0;

  assign wa = aw_got ? s_awaddr : AWADDR;
  assign wd = w_got  ? s_wdata  : WDATA;
  assign ws = w_got  ? s_wstrb  : WSTRB;

  always @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0;
      BVALID <= 1'b0; BRESP <= 2'b00;
      RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_hs_n <= aw_hs_n + 1; s_awaddr <= AWADDR; aw_got <= 1'b1; aw_cyc <= cyc;
      end
      if (WVALID && WREADY) begin
        w_hs_n <= w_hs_n + 1; s_wdata <= WDATA; s_wstrb <= WSTRB; w_got <= 1'b1; w_cyc <= cyc;
      end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !BVALID) begin
        if (slv_resp(wa) == 2'b00) slv_mem[wa[7:2]] <= merge(slv_mem[wa[7:2]], wd, ws);
        BRESP <= slv_resp(wa); BVALID <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (BVALID && BREADY) begin BVALID <= 1'b0; b_hs_n <= b_hs_n + 1; end
      if (ARVALID && ARREADY) begin
        ar_hs_n <= ar_hs_n + 1; s_araddr <= ARADDR; RVALID <= 1'b1; RRESP <= slv_resp(ARADDR);
        RDATA <= (ARADDR == 32'h40) ? 32'hE440_0040 :
                 (slv_resp(ARADDR) != 2'b00) ? 32'h0 : slv_mem[ARADDR[7:2]];
      end
      if (RVALID && RREADY) begin RVALID <= 1'b0; r_hs_n <= r_hs_n + 1; end
    end
  end

  // Reference: what each register should hold, and the sticky timeout expectation.
  logic [31:0] ref_mem [64] = '{default: '0};
  bit          exp_to = 1'b0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int unsigned aw_d,
                        input int unsigned w_d, input int unsigned ar_d);
    int          aw0, w0, b0, ar0, r0;
    int unsigned k, bn;
    bit          awd, wdn, bd, ard, rdn, fin, rsp_done, prev_v, prev_r, seen, zw;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
    exp_rs = slv_resp(a);
    if (wr) begin
      exp_rd = '0;
      if (exp_rs == 2'b00) for (int i = 0; i < SW; i++)
        if (s[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
    end else begin
      exp_rd = (a == 32'h40) ? 32'hE440_0040 : (exp_rs != 2'b00) ? 32'h0 : ref_mem[a[7:2]];
    end
    zw = !rand_rdy && aw_d == 0 && w_d == 0 && ar_d == 0;
    @(negedge ACLK);
    chk("cmd_ready_idle", 64'(CMD_READY), 64'(1));
    k = cyc;
    aw_blk = k + 1 + aw_d; w_blk = k + 1 + w_d; ar_blk = k + 1 + ar_d;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    RSP_READY = !rand_rdy;
    @(negedge ACLK);
    CMD_VALID = 1'b0; CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_WSTRB = SW'($urandom);
    bn = 0; rsp_done = 0; prev_v = 0; prev_r = 0; seen = 0;
    for (int g = 0; g < 400; g++) begin
      if (g > 0) @(negedge ACLK);
      if (prev_v && prev_r) rsp_done = 1;
      awd = aw_hs_n > aw0; wdn = w_hs_n > w0; bd = b_hs_n > b0;
      ard = ar_hs_n > ar0; rdn = r_hs_n > r0;
      fin = wr ? bd : rdn;
      chk("timeout", 64'(TIMEOUT), 64'(exp_to));
      if (!fin) begin
        bn++;
        if (bn == TO) exp_to = 1'b1;
      end
      chk("awvalid", 64'(AWVALID), 64'(wr && !awd));
      chk("wvalid", 64'(WVALID), 64'(wr && !wdn));
      chk("bready", 64'(BREADY), 64'(wr && awd && wdn && !bd));
      chk("arvalid", 64'(ARVALID), 64'(!wr && !ard));
      chk("rready", 64'(RREADY), 64'(!wr && ard && !rdn));
      chk("rsp_valid", 64'(RSP_VALID), 64'(fin && !rsp_done));
      chk("cmd_ready", 64'(CMD_READY), 64'(rsp_done));
      if (AWVALID) chk("awaddr", 64'(AWADDR), 64'(a));
      if (WVALID) chk("wdata", 64'({WSTRB, WDATA}), 64'({s, d}));
      if (ARVALID) chk("araddr", 64'(ARADDR), 64'(a));
      if (RSP_VALID) begin
        if (!seen && zw) chk("latency", 64'(cyc - k), 64'(3));
        seen = 1;
        chk("rsp_write", 64'(RSP_WRITE), 64'(wr));
        chk("rsp_rdata", 64'(RSP_RDATA), 64'(exp_rd));
        chk("rsp_resp", 64'(RSP_RESP), 64'(exp_rs));
      end
      if (rsp_done) break;
      prev_v = RSP_VALID;
      RSP_READY = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_r = RSP_READY;
    end
    if (!rsp_done) chk("txn_budget", 64'(0), 64'(1));
    RSP_READY = 1'b0;
    chk("aw_count", 64'(aw_hs_n - aw0), 64'(wr));
    chk("w_count", 64'(w_hs_n - w0), 64'(wr));
    chk("b_count", 64'(b_hs_n - b0), 64'(wr));
    chk("ar_count", 64'(ar_hs_n - ar0), 64'(!wr));
    chk("r_count", 64'(r_hs_n - r0), 64'(!wr));
    if (wr) chk("slv_awaddr", 64'(s_awaddr), 64'(a));
    else    chk("slv_araddr", 64'(s_araddr), 64'(a));
  endtask

  initial begin
    logic [AW-1:0] ra;
    repeat (2) @(negedge ACLK);
    chk("reset_cmd_ready", 64'(CMD_READY), 64'(0));
    chk("reset_all_zero", 64'(|{CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, TIMEOUT,
        AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY}), 64'(0));
    ARESET = 1'b1;

    // AW three cycles ahead of W
    do_txn(1'b1, 32'h4, 32'h1234_5678, 4'hF, 0, 3, 0);
    chk("w_after_aw", 64'(w_cyc - aw_cyc), 64'(3));
    // W ahead of AW, then both together
    do_txn(1'b1, 32'h8, 32'hCAFE_0008, 4'hF, 2, 0, 0);
    chk("aw_after_w", 64'(aw_cyc - w_cyc), 64'(2));
    do_txn(1'b1, 32'hC, 32'hBEEF_000C, 4'hF, 0, 0, 0);
    chk("aw_w_same", 64'(aw_cyc - w_cyc), 64'(0));
    do_txn(1'b0, 32'h4, '0, '0, 0, 0, 0);

    // Register sweep under random READY/RSP_READY backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) do_txn(1'b1, AW'(4 * i), DW'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 16; i++) do_txn(1'b0, AW'(4 * i), '0, '0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h40 :
           ($urandom_range(0, 7) == 0) ? 32'h200 : AW'(4 * $urandom_range(0, 15));
      do_txn(1'($urandom), ra, $urandom, SW'($urandom), 0, 0, 0);
    end
    rand_rdy = 1'b0;

    // Error responses pass through
    do_txn(1'b0, 32'h40, '0, '0, 0, 0, 0);
    do_txn(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, 0, 0, 0);
    do_txn(1'b0, 32'h300, '0, '0, 0, 0, 0);

    // Reset while ARVALID is waiting on a stalled slave
    @(negedge ACLK);
    ar_blk = cyc + 100;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h8;
    @(negedge ACLK);
    CMD_VALID = 1'b0;
    @(negedge ACLK);
    chk("arvalid_stalled", 64'(ARVALID), 64'(1));
    #2 ARESET = 1'b0;
    #1;
    chk("async_arvalid", 64'(ARVALID), 64'(0));
    chk("async_cmd_ready", 64'(CMD_READY), 64'(0));
    chk("async_all_zero", 64'(|{CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, TIMEOUT,
        AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY}), 64'(0));
    exp_to = 1'b0;
    ar_blk = 0;
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("post_reset_ready", 64'(CMD_READY), 64'(1));
    chk("post_reset_timeout", 64'(TIMEOUT), 64'(0));
    do_txn(1'b0, 32'h8, '0, '0, 0, 0, 0);

    // AWREADY withheld for 20 cycles: TIMEOUT sets after busy cycle 8, write still completes
    do_txn(1'b1, 32'h30, 32'h0BAD_F00D, 4'h5, 20, 0, 0);
    chk("timeout_sticky", 64'(TIMEOUT), 64'(1));
    do_txn(1'b0, 32'h30, '0, '0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_budget: got expired, expected completion");
    $fatal(1, "time budget exceeded");
  end

endmodule
